// File: rtl/reset_seq_pkg.sv
// Shared definitions for the reset sequencer: FSM state encoding,
// legal parameter ranges and the counter sizing helper.
package reset_seq_pkg;

   // Sequencer states: wait for synchronised release, hold off, stagger outputs, idle.
   typedef enum logic [1:0] {
      HOLD    = 2'd0,
      STRETCH = 2'd1,
      RELEASE = 2'd2,
      RUN     = 2'd3
   } seq_state_e;

   // Legal parameter ranges.
   localparam int SYNC_STAGES_MIN    = 2;
   localparam int SYNC_STAGES_MAX    = 8;
   localparam int NUM_CH_MIN         = 1;
   localparam int NUM_CH_MAX         = 16;
   localparam int STRETCH_CYCLES_MIN = 1;
   localparam int STRETCH_CYCLES_MAX = 65535;
   localparam int STEP_CYCLES_MIN    = 1;
   localparam int STEP_CYCLES_MAX    = 255;

   // Counter width large enough for the longer of the two intervals.
   function automatic int cnt_width(input int stretch_cycles, input int step_cycles);
      int longest;
      longest = (stretch_cycles > step_cycles) ? stretch_cycles : step_cycles;
      return $clog2(longest + 1);
   endfunction

endpackage

// File: rtl/reset_sync_stages.sv
// Reset release synchroniser: a chain of flops cleared asynchronously,
// with a constant 1 shifted in so release reaches the core on CLK.
module reset_sync_stages
   import reset_seq_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic CLK,
   input  logic RESETINn,
   output logic sync_out
);

   logic [SYNC_STAGES-1:0] sync_reg;

   genvar gi;
   generate
      for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
         if (gi == 0) begin : g_first
            // First stage loads a constant 1 once reset is released.
            always_ff @(posedge CLK or negedge RESETINn) begin
               if (!RESETINn) sync_reg[gi] <= 1'b0;
               else           sync_reg[gi] <= 1'b1;
            end
         end else begin : g_next
            // Later stages shift the release along the chain.
            always_ff @(posedge CLK or negedge RESETINn) begin
               if (!RESETINn) sync_reg[gi] <= 1'b0;
               else           sync_reg[gi] <= sync_reg[gi-1];
            end
         end
      end
   endgenerate

   assign sync_out = sync_reg[SYNC_STAGES-1];

endmodule

// File: rtl/reset_sync_seq.sv
// Reset synchroniser and sequencer: asserts all channel resets
// asynchronously, releases them on CLK after a stretch interval, one
// channel every STEP_CYCLES, and accepts a software reset once running.
module reset_sync_seq
   import reset_seq_pkg::*;
#(
   parameter int SYNC_STAGES    = 2,
   parameter int NUM_CH         = 3,
   parameter int STRETCH_CYCLES = 16,
   parameter int STEP_CYCLES    = 4
) (
   input  logic              CLK,
   input  logic              RESETINn,
   input  logic              SWRSTREQ,
   output logic [NUM_CH-1:0] RESETOUTn,
   output logic              BUSY
);

   localparam int CW = cnt_width(STRETCH_CYCLES, STEP_CYCLES);
   // Counter values at which the current interval ends.
   localparam logic [CW-1:0] STRETCH_LAST = CW'(STRETCH_CYCLES - 1);
   localparam logic [CW-1:0] STEP_LAST    = CW'(STEP_CYCLES - 1);

   seq_state_e        state_reg, state_next;
   logic [CW-1:0]     cnt_reg, cnt_next;
   logic [NUM_CH-1:0] out_reg, out_next, out_step;
   logic              busy_reg, busy_next;
   logic              sync_out;

   reset_sync_stages #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .CLK     (CLK),
      .RESETINn(RESETINn),
      .sync_out(sync_out)
   );

   // Output vector with the next channel (lowest still-low index) released.
   always_comb begin
      out_step    = out_reg;
      out_step[0] = 1'b1;
      for (int i = 1; i < NUM_CH; i++) begin
         out_step[i] = out_reg[i] | out_reg[i-1];
      end
   end

   // Next-state, counter and channel-output decisions.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      out_next   = out_reg;
      case (state_reg)
         HOLD: begin
            // The edge that sees the synchroniser release counts as the
            // first stretch edge; a one-cycle stretch therefore releases
            // channel 0 straight from here.
            if (sync_out) begin
               if (STRETCH_CYCLES == 1) begin
                  out_next   = NUM_CH'(1);
                  cnt_next   = '0;
                  state_next = RELEASE;
               end else begin
                  cnt_next   = CW'(1);
                  state_next = STRETCH;
               end
            end
         end
         STRETCH: begin
            if (cnt_reg == STRETCH_LAST) begin
               out_next   = NUM_CH'(1);
               cnt_next   = '0;
               state_next = RELEASE;
            end else begin
               cnt_next = cnt_reg + CW'(1);
            end
         end
         RELEASE: begin
            // Leave once the last channel is seen high, so RELEASE spans
            // at least one cycle even with a single channel.
            if (out_reg[NUM_CH-1]) begin
               cnt_next   = '0;
               state_next = RUN;
            end else if (cnt_reg == STEP_LAST) begin
               out_next = out_step;
               cnt_next = '0;
            end else begin
               cnt_next = cnt_reg + CW'(1);
            end
         end
         RUN: begin
            // Software reset restarts the stretch; the request edge is edge 0.
            if (SWRSTREQ) begin
               out_next   = '0;
               cnt_next   = '0;
               state_next = STRETCH;
            end
         end
         default: begin
            state_next = HOLD;
         end
      endcase
      busy_next = ~&out_next;
   end

   // State, counter and output flops, all cleared by RESETINn.
   always_ff @(posedge CLK or negedge RESETINn) begin
      if (!RESETINn) begin
         state_reg <= HOLD;
         cnt_reg   <= '0;
         out_reg   <= '0;
         busy_reg  <= 1'b1;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         out_reg   <= out_next;
         busy_reg  <= busy_next;
      end
   end

   assign RESETOUTn = out_reg;
   assign BUSY      = busy_reg;

endmodule

// File: tb/tb_reset_sync_seq.sv
// Bench for reset_sync_seq: two instances (default parameters and a
// single-channel variant) against an edge-timing reference model.
module tb_reset_sync_seq;

   localparam int A_S = 2, A_N = 3, A_ST = 16, A_STEP = 4;
   localparam int B_S = 3, B_N = 1, B_ST = 1,  B_STEP = 4;

   logic          CLK = 1'b0;
   logic          RESETINn = 1'b0;
   logic          SWRSTREQ = 1'b0;
   logic [A_N-1:0] out_a;
   logic [B_N-1:0] out_b;
   logic          busy_a, busy_b;

   int errors = 0;
   int checks = 0;
   int edge_no = 0;    // edges since reset release (edge 1 = first rise with RESETINn high)
   int rel0_a, rel0_b; // edge at which channel 0 is scheduled to rise

   always #5 CLK = ~CLK;

   reset_sync_seq #(
      .SYNC_STAGES(A_S), .NUM_CH(A_N), .STRETCH_CYCLES(A_ST), .STEP_CYCLES(A_STEP)
   ) dut_a (
      .CLK(CLK), .RESETINn(RESETINn), .SWRSTREQ(SWRSTREQ), .RESETOUTn(out_a), .BUSY(busy_a)
   );

   reset_sync_seq #(
      .SYNC_STAGES(B_S), .NUM_CH(B_N), .STRETCH_CYCLES(B_ST), .STEP_CYCLES(B_STEP)
   ) dut_b (
      .CLK(CLK), .RESETINn(RESETINn), .SWRSTREQ(SWRSTREQ), .RESETOUTn(out_b), .BUSY(busy_b)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s edge=%0d observed=%0h expected=%0h", tag, edge_no, obs, exp);
      end
   endtask

   // Channel i is high once edge e has reached rel0 + i*step.
   function automatic logic [31:0] exp_out(input int e, input int rel0, input int n, input int step);
      logic [31:0] v;
      v = '0;
      for (int i = 0; i < n; i++) if (e >= rel0 + i * step) v[i] = 1'b1;
      return v;
   endfunction

   task automatic model_reset();
      edge_no = 0;
      rel0_a  = A_S + A_ST;
      rel0_b  = B_S + B_ST;
   endtask

   // One clock edge: drive request, update model, compare on the falling edge.
   task automatic step_edge(input logic sw);
      logic [31:0] ea, eb;
      SWRSTREQ = sw;
      @(posedge CLK);
      edge_no++;
      // Running (and able to accept a request) from two edges after the last channel rose.
      if (sw && edge_no >= rel0_a + (A_N - 1) * A_STEP + 2) rel0_a = edge_no + A_ST;
      if (sw && edge_no >= rel0_b + (B_N - 1) * B_STEP + 2) rel0_b = edge_no + B_ST;
      @(negedge CLK);
      ea = exp_out(edge_no, rel0_a, A_N, A_STEP);
      eb = exp_out(edge_no, rel0_b, B_N, B_STEP);
      check("out_a", 32'(out_a), ea);
      check("busy_a", 32'(busy_a), 32'(ea != 32'h7));
      check("out_b", 32'(out_b), eb);
      check("busy_b", 32'(busy_b), 32'(eb != 32'h1));
      $display("edge %0d sw=%0b out_a=%b busy_a=%0b out_b=%b busy_b=%0b",
               edge_no, sw, out_a, busy_a, out_b, busy_b);
   endtask

   // Short RESETINn pulse between clock edges; outputs must drop without a clock.
   task automatic async_glitch();
      #2 RESETINn = 1'b0;
      #1;
      check("glitch_out_a", 32'(out_a), 32'h0);
      check("glitch_busy_a", 32'(busy_a), 32'h1);
      check("glitch_out_b", 32'(out_b), 32'h0);
      check("glitch_busy_b", 32'(busy_b), 32'h1);
      $display("async reset pulse at edge %0d out_a=%b out_b=%b", edge_no, out_a, out_b);
      #1 RESETINn = 1'b1;
      model_reset();
   endtask

   // Boot sequence with fixed timing checks for both instances.
   task automatic boot_seq(input logic sw);
      for (int k = 1; k <= 30; k++) begin
         step_edge(sw);
         if (edge_no == 17) check("boot_a_e17", 32'(out_a), 32'b000);
         if (edge_no == 18) check("boot_a_e18", 32'(out_a), 32'b001);
         if (edge_no == 21) check("boot_a_e21", 32'(out_a), 32'b001);
         if (edge_no == 22) check("boot_a_e22", 32'(out_a), 32'b011);
         if (edge_no == 25) check("boot_busy_a_e25", 32'(busy_a), 32'h1);
         if (edge_no == 26) check("boot_a_e26", 32'(out_a), 32'b111);
         if (edge_no == 26) check("boot_busy_a_e26", 32'(busy_a), 32'h0);
         if (edge_no == 3)  check("boot_b_e3", 32'(out_b), 32'h0);
         if (edge_no == 4)  check("boot_b_e4", 32'(out_b), 32'h1);
         if (edge_no == 4)  check("boot_busy_b_e4", 32'(busy_b), 32'h0);
      end
   endtask

   initial begin
      model_reset();
      // Power-on reset held for five cycles.
      for (int k = 0; k < 5; k++) begin
         @(negedge CLK);
         check("por_out_a", 32'(out_a), 32'h0);
         check("por_busy_a", 32'(busy_a), 32'h1);
         check("por_out_b", 32'(out_b), 32'h0);
         $display("reset cycle %0d out_a=%b busy_a=%0b", k, out_a, busy_a);
      end
      #1 RESETINn = 1'b1;
      model_reset();
      boot_seq(1'b0);

      // Software reset pulse at edge 40.
      while (edge_no < 39) step_edge(1'b0);
      step_edge(1'b1);
      check("swr_a_e40", 32'(out_a), 32'b000);
      while (edge_no < 64) begin
         step_edge(1'b0);
         if (edge_no == 55) check("swr_a_e55", 32'(out_a), 32'b000);
         if (edge_no == 56) check("swr_a_e56", 32'(out_a), 32'b001);
         if (edge_no == 60) check("swr_a_e60", 32'(out_a), 32'b011);
         if (edge_no == 64) check("swr_a_e64", 32'(out_a), 32'b111);
      end

      // Glitch while running, then full replay.
      async_glitch();
      boot_seq(1'b0);

      // Reset dropped mid-release at edge 23, then full replay.
      async_glitch();
      while (edge_no < 23) step_edge(1'b0);
      async_glitch();
      boot_seq(1'b0);

      // Request held high through stretch and release: first effect in RUN.
      async_glitch();
      boot_seq(1'b1);
      while (edge_no < 45) begin
         step_edge(1'b1);
         if (edge_no == 31) check("hold_a_e31", 32'(out_a), 32'b000);
         if (edge_no == 43) check("hold_a_e43", 32'(out_a), 32'b000);
         if (edge_no == 44) check("hold_a_e44", 32'(out_a), 32'b001);
      end

      // Randomised requests and reset glitches against the model.
      for (int k = 0; k < 400; k++) begin
         if ($urandom_range(0, 59) == 0) async_glitch();
         step_edge($urandom_range(0, 5) == 0);
      end

      SWRSTREQ = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
